// File: rtl/id_ex_stage.sv
// Decode/execute stage: operand forwarding, ALU-select decode, load-use stall and a
// single-entry valid/ready output register. Define ID_EX_PERF_EN to build the stall/flush counters.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [RA_W-1:0] rs1_addr,
    input  logic [RA_W-1:0] rs2_addr,
    input  logic [RA_W-1:0] rd_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            ex_fwd_we,
    input  logic [RA_W-1:0] ex_fwd_rd,
    input  logic [XLEN-1:0] ex_fwd_data,
    input  logic            wb_fwd_we,
    input  logic [RA_W-1:0] wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_sel,
    output logic [XLEN-1:0] store_data,
    output logic [RA_W-1:0] out_rd,
    output logic            out_reg_write,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic            out_is_branch,
    output logic            out_illegal,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
);

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_sel_e;

    alu_sel_e        dec_sel, sel_q;
    logic            dec_imm, dec_rw, dec_ld, dec_st, dec_br, dec_ill, dec_use1, dec_use2;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;
    logic            hazard, accept;

    always_comb begin
        dec_sel  = ALU_ADD;
        dec_imm  = 1'b0;
        dec_rw   = 1'b0;
        dec_ld   = 1'b0;
        dec_st   = 1'b0;
        dec_br   = 1'b0;
        dec_ill  = 1'b0;
        dec_use2 = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_rw   = 1'b1;
                dec_use2 = 1'b1;
                case (funct3)
                    3'b000:  dec_sel = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b010:  dec_sel = ALU_SLT;
                    3'b110:  dec_sel = ALU_OR;
                    3'b111:  dec_sel = ALU_AND;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec_rw  = 1'b1;
                dec_imm = 1'b1;
                case (funct3)
                    3'b000:  dec_sel = ALU_ADD;
                    3'b010:  dec_sel = ALU_SLT;
                    3'b110:  dec_sel = ALU_OR;
                    3'b111:  dec_sel = ALU_AND;
                    default: dec_ill = 1'b1;
                endcase
            end
            7'b0000011: begin
                dec_rw  = 1'b1;
                dec_ld  = 1'b1;
                dec_imm = 1'b1;
                dec_ill = (funct3 != 3'b010);
            end
            7'b0100011: begin
                dec_st   = 1'b1;
                dec_imm  = 1'b1;
                dec_use2 = 1'b1;
                dec_ill  = (funct3 != 3'b010);
            end
            7'b1100011: begin
                dec_sel  = ALU_SUB;
                dec_br   = 1'b1;
                dec_use2 = 1'b1;
                dec_ill  = (funct3 != 3'b000);
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal encodings pass through with every side-effect flag cleared.
        if (dec_ill) begin
            dec_sel  = ALU_ADD;
            dec_imm  = 1'b0;
            dec_rw   = 1'b0;
            dec_ld   = 1'b0;
            dec_st   = 1'b0;
            dec_br   = 1'b0;
            dec_use2 = 1'b0;
        end
        dec_use1 = !dec_ill;
    end

    assign rs1_fwd = (rs1_addr == '0)                         ? '0          :
                     (ex_fwd_we && (ex_fwd_rd == rs1_addr))   ? ex_fwd_data :
                     (wb_fwd_we && (wb_fwd_rd == rs1_addr))   ? wb_fwd_data : rs1_data;
    assign rs2_fwd = (rs2_addr == '0)                         ? '0          :
                     (ex_fwd_we && (ex_fwd_rd == rs2_addr))   ? ex_fwd_data :
                     (wb_fwd_we && (wb_fwd_rd == rs2_addr))   ? wb_fwd_data : rs2_data;

    assign hazard = out_valid && out_is_load && (out_rd != '0) &&
                    ((dec_use1 && (rs1_addr == out_rd)) || (dec_use2 && (rs2_addr == out_rd)));
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready && !flush;
    assign alu_sel  = sel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            sel_q         <= ALU_ADD;
            store_data    <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
            out_is_load   <= 1'b0;
            out_is_store  <= 1'b0;
            out_is_branch <= 1'b0;
            out_illegal   <= 1'b0;
        end else begin
            if (flush)          out_valid <= 1'b0;
            else if (accept)    out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
            if (accept) begin
                alu_a         <= rs1_fwd;
                alu_b         <= dec_imm ? imm : rs2_fwd;
                sel_q         <= dec_sel;
                store_data    <= rs2_fwd;
                out_rd        <= rd_addr;
                out_reg_write <= dec_rw;
                out_is_load   <= dec_ld;
                out_is_store  <= dec_st;
                out_is_branch <= dec_br;
                out_illegal   <= dec_ill;
            end
        end
    end

`ifdef ID_EX_PERF_EN
    logic [31:0] stall_q, flush_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (in_valid && !in_ready && !flush) stall_q <= stall_q + 32'd1;
            if (flush && (out_valid || in_valid)) flush_q <= flush_q + 32'd1;
        end
    end
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
